// File: rtl/seg_pkg.sv
// Shared constants and types for the mm:ss seven-segment scanner.
// Segment patterns are active-low, ordered seg[6:0] = g..a.
package seg_pkg;

   typedef logic [1:0] digit_idx_t;

   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   function automatic logic [6:0] seg_lut(input logic [3:0] digit);
      logic [6:0] pat;
      case (digit)
         4'd0:    pat = SEG_0;
         4'd1:    pat = SEG_1;
         4'd2:    pat = SEG_2;
         4'd3:    pat = SEG_3;
         4'd4:    pat = SEG_4;
         4'd5:    pat = SEG_5;
         4'd6:    pat = SEG_6;
         4'd7:    pat = SEG_7;
         4'd8:    pat = SEG_8;
         4'd9:    pat = SEG_9;
         default: pat = SEG_OFF;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// Splits a 0..63 binary value into tens/ones digits and returns both segment patterns.
// Purely combinational; values 60..63 map to tens digit 6 without clamping.
module seg7_digit_dec
   import seg_pkg::*;
(
   input  logic [5:0] val_i,
   output logic [6:0] tens_o,
   output logic [6:0] ones_o
);

   logic [2:0] tens;
   logic [3:0] ones;

   always_comb begin
      tens = 3'd0;
      if (val_i >= 6'd60)      tens = 3'd6;
      else if (val_i >= 6'd50) tens = 3'd5;
      else if (val_i >= 6'd40) tens = 3'd4;
      else if (val_i >= 6'd30) tens = 3'd3;
      else if (val_i >= 6'd20) tens = 3'd2;
      else if (val_i >= 6'd10) tens = 3'd1;
      ones = 4'(val_i - 6'(tens) * 6'd10);
   end

   assign tens_o = seg_lut({1'b0, tens});
   assign ones_o = seg_lut(ones);

endmodule

// File: rtl/seg_display_scan.sv
// Four-digit multiplexed mm:ss display driver with per-frame input snapshot.
// Define SEG_LZB_EN to blank the minutes-tens digit while minutes < 10.
module seg_display_scan
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 100000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] mm,
   input  logic [5:0] ss,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PrescMax = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] BlankEnd = PW'(BLANK_CYC);

   logic [PW-1:0] presc_q, presc_d;
   digit_idx_t    idx_q, idx_d;
   logic [5:0]    mm_snap_q, mm_snap_d;
   logic [5:0]    ss_snap_q, ss_snap_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          tick;
   logic [6:0]    ss_tens, ss_ones, mm_tens, mm_ones;
   logic [6:0]    digit_pat;
   logic          hide_d3;
   logic          active;

   seg7_digit_dec u_dec_ss (
      .val_i  (ss_snap_q),
      .tens_o (ss_tens),
      .ones_o (ss_ones)
   );

   seg7_digit_dec u_dec_mm (
      .val_i  (mm_snap_q),
      .tens_o (mm_tens),
      .ones_o (mm_ones)
   );

   assign tick = (presc_q == PrescMax);

   always_comb begin
      presc_d   = tick ? '0 : presc_q + 1'b1;
      idx_d     = tick ? idx_q + 2'd1 : idx_q;
      mm_snap_d = mm_snap_q;
      ss_snap_d = ss_snap_q;
      // Reload only at the frame boundary so all four digits show one value.
      if (tick && (idx_q == 2'd3)) begin
         mm_snap_d = mm;
         ss_snap_d = ss;
      end
   end

   always_comb begin
      unique case (idx_q)
         2'd0: digit_pat = ss_ones;
         2'd1: digit_pat = ss_tens;
         2'd2: digit_pat = mm_ones;
         2'd3: digit_pat = mm_tens;
         default: digit_pat = SEG_OFF;
      endcase
`ifdef SEG_LZB_EN
      hide_d3 = (mm_snap_q < 6'd10);
`else
      hide_d3 = 1'b0;
`endif
      active = (presc_q >= BlankEnd) && !((idx_q == 2'd3) && hide_d3);
      an_d   = active ? ~(4'b0001 << idx_q) : 4'b1111;
      seg_d  = active ? digit_pat : SEG_OFF;
      dp_d   = !(active && (idx_q == 2'd2));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= '0;
         idx_q     <= 2'd0;
         mm_snap_q <= 6'd0;
         ss_snap_q <= 6'd0;
         an_q      <= 4'b1111;
         seg_q     <= SEG_OFF;
         dp_q      <= 1'b1;
      end else begin
         presc_q   <= presc_d;
         idx_q     <= idx_d;
         mm_snap_q <= mm_snap_d;
         ss_snap_q <= ss_snap_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Directed bench for seg_display_scan with SCAN_DIV=8, BLANK_CYC=2.
// Honours SEG_LZB_EN the same way the design does.
module tb_seg_display_scan;

   localparam int unsigned ScanDiv  = 8;
   localparam int unsigned BlankCyc = 2;
`ifdef SEG_LZB_EN
   localparam bit Lzb = 1'b1;
`else
   localparam bit Lzb = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [5:0] mm;
   logic [5:0] ss;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] pat [10];
   logic [3:0] anode [4];

   seg_display_scan #(
      .SCAN_DIV  (ScanDiv),
      .BLANK_CYC (BlankCyc)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mm    (mm),
      .ss    (ss),
      .an    (an),
      .seg   (seg),
      .dp    (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Positions are frame offsets 0..31 of the state the sampled outputs reflect.
   task automatic run_slots(input int first, input int last, input int d0, input int d1,
                            input int d2, input int d3, input bit show3);
      int         k;
      int         p;
      bit         act;
      logic [6:0] exp_seg;
      for (int pos = first; pos <= last; pos++) begin
         k = pos / 8;
         p = pos % 8;
         @(posedge clk);
         #1;
         act = (p >= 2) && !((k == 3) && !show3);
         check($sformatf("an k%0d p%0d", k, p), {3'b000, an}, act ? {3'b000, anode[k]} : 7'h0F);
         check($sformatf("dp k%0d p%0d", k, p), {6'd0, dp}, (act && k == 2) ? 7'd0 : 7'd1);
         if (act) begin
            case (k)
               0:       exp_seg = pat[d0];
               1:       exp_seg = pat[d1];
               2:       exp_seg = pat[d2];
               default: exp_seg = pat[d3];
            endcase
            check($sformatf("seg k%0d p%0d", k, p), seg, exp_seg);
         end
      end
   endtask

   initial begin
      pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
      pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
      pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
      pat[9] = 7'b0010000;
      anode[0] = 4'b1110; anode[1] = 4'b1101; anode[2] = 4'b1011; anode[3] = 4'b0111;

      rst_n = 1'b0;
      mm    = 6'd12;
      ss    = 6'd34;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("rst an", {3'b000, an}, 7'h0F);
         check("rst seg", seg, 7'b1111111);
         check("rst dp", {6'd0, dp}, 7'd1);
      end
      rst_n = 1'b1;

      // Snapshot is still zero for the first frame; 12:34 is captured at its end.
      run_slots(0, 31, 0, 0, 0, 0, !Lzb);

      run_slots(0, 11, 4, 3, 2, 1, 1'b1);
      ss = 6'd35;
      mm = 6'd45;
      run_slots(12, 31, 4, 3, 2, 1, 1'b1);

      mm = 6'd63;
      ss = 6'd60;
      run_slots(0, 31, 5, 3, 5, 4, 1'b1);

      mm = 6'd0;
      ss = 6'd0;
      run_slots(0, 31, 0, 6, 3, 6, 1'b1);

      mm = 6'd9;
      ss = 6'd7;
      run_slots(0, 31, 0, 0, 0, 0, !Lzb);

      mm = 6'd10;
      ss = 6'd0;
      run_slots(0, 31, 7, 0, 9, 0, !Lzb);

      run_slots(0, 20, 0, 0, 0, 1, 1'b1);
      // DUT now sits at index 2, prescaler 5 with an=1011 showing.
      check("pre-rst an", {3'b000, an}, 7'b0001011);
      rst_n = 1'b0;
      #1;
      check("midrst an", {3'b000, an}, 7'h0F);
      check("midrst seg", seg, 7'b1111111);
      check("midrst dp", {6'd0, dp}, 7'd1);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("midrst hold an", {3'b000, an}, 7'h0F);
      end
      rst_n = 1'b1;
      run_slots(0, 31, 0, 0, 0, 0, !Lzb);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
